cnn_layer_scheduler: RTL

Top-level sequencer for the ECG CNN accelerator. It launches the per-layer control procedures (conv/ReLU/max-pool) one after another and streams the feature map into each layer over a valid/ready handshake. It ping-pongs the feature-buffer bank between layers, supervises every layer with a no-progress watchdog, and reports completion or error to the host-side control unit.

---
 rtl/cnn_layer_scheduler.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/cnn_layer_scheduler.sv
// Sequences the conv/ReLU/pool layer controllers, streams each one its feature map and ping-pongs banks.
// Optional per-layer cycle counter is built only when SCHED_PERF_EN is defined; otherwise perf_cycles reads 0.
module cnn_layer_scheduler #(
    parameter int NUM_LAYERS = 3,
    parameter int LAYER_W    = 2,
    parameter int SAMPLES    = 500,
    parameter int ADDR_W     = 9,
    parameter int TIMEOUT    = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  feed_valid,
    input  logic                  feed_ready,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_bank,
    output logic [LAYER_W-1:0]    layer_sel,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           perf_cycles
);

    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]   TMR_LIMIT = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   TMR_MAX   = '1;
    localparam logic [ADDR_W-1:0]  ADDR_LAST = ADDR_W'(SAMPLES - 1);
    localparam logic [LAYER_W-1:0] SEL_LAST  = LAYER_W'(NUM_LAYERS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_NEXT   = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [LAYER_W-1:0]    sel_q, sel_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d, tmr_inc;
    logic                  err_q, err_d;
    logic [NUM_LAYERS-1:0] sel_onehot;
    logic                  done_hit;
    logic                  accept;
    logic                  timed_out;

    // Only the selected layer's done bit is ever looked at.
    generate
        for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_sel
            assign sel_onehot[gi]  = (sel_q == LAYER_W'(gi));
            assign layer_start[gi] = (state_q == S_LAUNCH) && sel_onehot[gi];
        end
    endgenerate

    assign done_hit  = |(layer_done & sel_onehot);
    assign accept    = (state_q == S_STREAM) && feed_ready;
    assign timed_out = (tmr_q >= TMR_LIMIT);
    assign tmr_inc   = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        addr_d  = addr_q;
        err_d   = err_q;
        tmr_d   = '0;
        case (state_q)
            S_IDLE, S_ERROR: begin
                if (start) begin
                    state_d = S_LAUNCH;
                    sel_d   = '0;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LAUNCH: begin
                state_d = S_STREAM;
            end
            S_STREAM: begin
                tmr_d = tmr_inc;
                if (done_hit) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end else if (accept) begin
                    tmr_d = '0;
                    if (addr_q == ADDR_LAST) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end
            end
            S_DRAIN: begin
                tmr_d = tmr_inc;
                if (done_hit) begin
                    state_d = S_NEXT;
                end else if (timed_out) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                end
            end
            S_NEXT: begin
                if (sel_q == SEL_LAST) begin
                    state_d = S_FINISH;
                end else begin
                    state_d = S_LAUNCH;
                    sel_d   = sel_q + LAYER_W'(1);
                    addr_d  = '0;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything and leaves the error flag exactly as it was.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            sel_d   = sel_q;
            addr_d  = addr_q;
            err_d   = err_q;
            tmr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            addr_q  <= '0;
            tmr_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            tmr_q   <= tmr_d;
            err_q   <= err_d;
        end
    end

    assign feed_valid = (state_q == S_STREAM);
    assign busy       = (state_q == S_LAUNCH) || (state_q == S_STREAM) ||
                        (state_q == S_DRAIN)  || (state_q == S_NEXT);
    assign done       = (state_q == S_FINISH);
    assign err        = err_q;
    assign rd_addr    = addr_q;
    assign layer_sel  = sel_q;
    assign rd_bank    = sel_q[0];

`ifdef SCHED_PERF_EN
    logic [31:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] perf_q, perf_d;

    assign cnt_inc = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    // The LAUNCH cycle itself counts as the first cycle of the layer.
    always_comb begin
        cnt_d  = cnt_q;
        perf_d = perf_q;
        case (state_q)
            S_LAUNCH:                 cnt_d = 32'd1;
            S_STREAM, S_DRAIN, S_NEXT: cnt_d = cnt_inc;
            default:                  cnt_d = cnt_q;
        endcase
        if ((state_q == S_NEXT) && !abort) begin
            perf_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            perf_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule
